// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one valid/ready bus transaction per memory instruction,
// stalling the pipeline until the response returns; loads are aligned and extended.
module mem_lsu #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_load,
    input  logic                  inst_store,
    input  logic [1:0]            mem_size,
    input  logic                  load_unsigned,
    input  logic [ADDR_WIDTH-1:0] eff_addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_wen,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [7:0]            req_wstrb,
    output logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  resp_valid,
    input  logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  lsu_stall,
    output logic                  lsu_done,
    output logic [DATA_WIDTH-1:0] lsu_odata,
    output logic                  lsu_misalign
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_t;

    state_t          state_q, state_d;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [2:0]      off_q;
    logic            mem_op;
    logic            misaligned;
    logic            accept;
    logic [7:0]      base_strb;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] load_val;

    assign mem_op = inst_load | inst_store;

    always_comb begin
        misaligned = 1'b0;
        base_strb  = 8'h01;
        unique case (mem_size)
            2'b00: begin misaligned = 1'b0;             base_strb = 8'h01; end
            2'b01: begin misaligned = eff_addr[0];      base_strb = 8'h03; end
            2'b10: begin misaligned = |eff_addr[1:0];   base_strb = 8'h0F; end
            2'b11: begin misaligned = |eff_addr[2:0];   base_strb = 8'hFF; end
            default: ;
        endcase
    end

    assign accept       = (state_q == StIdle) && mem_op && !misaligned;
    assign lsu_misalign = (state_q == StIdle) && mem_op && misaligned;
    assign lsu_stall    = accept || (state_q == StReq) || (state_q == StWait);
    assign lsu_done     = (state_q == StDone);
    assign req_valid    = (state_q == StReq);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StReq;
            StReq:  if (req_ready) state_d = StWait;
            StWait: if (resp_valid) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Select the addressed lanes and extend from the top bit of the access size.
    always_comb begin
        shifted  = resp_rdata >> {off_q, 3'b000};
        load_val = shifted;
        unique case (size_q)
            2'b00: load_val = uns_q ? {56'd0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
            2'b01: load_val = uns_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            2'b10: load_val = uns_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            2'b11: load_val = shifted;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            req_wen   <= 1'b0;
            req_addr  <= '0;
            req_wstrb <= 8'h00;
            req_wdata <= '0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            off_q     <= 3'b000;
            lsu_odata <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_wen   <= inst_store;
                req_addr  <= {eff_addr[ADDR_WIDTH-1:3], 3'b000};
                req_wstrb <= inst_store ? (base_strb << eff_addr[2:0]) : 8'h00;
                req_wdata <= store_data << {eff_addr[2:0], 3'b000};
                size_q    <= mem_size;
                uns_q     <= load_unsigned;
                off_q     <= eff_addr[2:0];
            end
            if ((state_q == StWait) && resp_valid && !req_wen) begin
                lsu_odata <= load_val;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: transaction-level reference model compared every cycle,
// plus directed cases with hand-computed results and a randomized run.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_load = 1'b0, inst_store = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic        load_unsigned = 1'b0;
    logic [63:0] eff_addr = '0, store_data = '0;
    logic        req_valid, req_ready = 1'b0, req_wen;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wstrb;
    logic        resp_valid = 1'b0;
    logic [63:0] resp_rdata = '0;
    logic        lsu_stall, lsu_done, lsu_misalign;
    logic [63:0] lsu_odata;

    int errors = 0;
    int checks = 0;

    mem_lsu #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk(clk), .rst(rst), .inst_load(inst_load), .inst_store(inst_store),
        .mem_size(mem_size), .load_unsigned(load_unsigned), .eff_addr(eff_addr),
        .store_data(store_data), .req_valid(req_valid), .req_ready(req_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_wstrb(req_wstrb),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_odata(lsu_odata),
        .lsu_misalign(lsu_misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_aligned(input logic [63:0] a, input logic [1:0] sz);
        return (a % (64'd1 << sz)) == 0;
    endfunction

    function automatic logic [63:0] load_result(input logic [63:0] rd, input int off,
                                                input int sz, input bit uns);
        logic [63:0] v, mask;
        int nbits;
        nbits = 8 << sz;
        v = rd >> (8 * off);
        if (sz == 3) return v;
        mask = (64'd1 << nbits) - 64'd1;
        v = v & mask;
        if (!uns && v[nbits-1]) v = v | ~mask;
        return v;
    endfunction

    // Reference model: one pending transaction record plus the last load result.
    bit          have_txn, acked, responded, m_load, m_uns;
    logic [1:0]  m_size;
    int          m_off;
    logic [63:0] m_addr, m_wdata, exp_odata;
    logic [7:0]  m_wstrb;
    int          done_pulses = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            have_txn = 0; acked = 0; responded = 0; exp_odata = '0;
        end else if (responded) begin
            have_txn = 0; responded = 0;
        end else if (!have_txn) begin
            if ((inst_load || inst_store) && is_aligned(eff_addr, mem_size)) begin
                have_txn = 1; acked = 0;
                m_load  = inst_load;
                m_size  = mem_size;
                m_uns   = load_unsigned;
                m_off   = int'(eff_addr % 8);
                m_addr  = eff_addr - (eff_addr % 8);
                m_wstrb = inst_store ? 8'(((16'd1 << (1 << mem_size)) - 16'd1) << m_off) : 8'h00;
                m_wdata = store_data << (8 * m_off);
            end
        end else if (!acked) begin
            if (req_ready) acked = 1;
        end else if (resp_valid) begin
            responded = 1;
            if (m_load) exp_odata = load_result(resp_rdata, m_off, int'(m_size), m_uns);
        end
    end

    always @(negedge clk) begin
        bit op, al;
        op = inst_load || inst_store;
        al = is_aligned(eff_addr, mem_size);
        check("req_valid", 64'(req_valid), 64'(have_txn && !acked));
        check("lsu_stall", 64'(lsu_stall), 64'((!have_txn && op && al) || (have_txn && !responded)));
        check("lsu_done", 64'(lsu_done), 64'(responded));
        check("lsu_misalign", 64'(lsu_misalign), 64'(!have_txn && op && !al));
        check("lsu_odata", lsu_odata, exp_odata);
        if (have_txn && !acked) begin
            check("req_wen", 64'(req_wen), 64'(!m_load));
            check("req_addr", req_addr, m_addr);
            check("req_wstrb", 64'(req_wstrb), 64'(m_wstrb));
            check("req_wdata", req_wdata, m_wdata);
        end
        if (lsu_done) done_pulses++;
    end

    logic [63:0] cap_addr, cap_wdata;
    logic [7:0]  cap_wstrb;
    logic        cap_wen, cap_mis, cap_stall, cap_req;
    time         t_done, t_req;

    // Caller is at posedge+1; on return the instruction has been retired and cleared.
    task automatic run_op(input bit l, input bit s, input logic [1:0] sz, input bit u,
                          input logic [63:0] a, input logic [63:0] d, input logic [63:0] rd,
                          input int rdly, input int pdly);
        int n;
        inst_load = l; inst_store = s; mem_size = sz; load_unsigned = u;
        eff_addr = a; store_data = d; req_ready = 0; resp_valid = 0;
        #1;
        cap_mis = lsu_misalign; cap_stall = lsu_stall;
        if (!is_aligned(a, sz) || !(l || s)) begin
            @(posedge clk); #1;
            cap_req = req_valid;
            inst_load = 0; inst_store = 0;
            return;
        end
        n = 0;
        while (!req_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("req_valid timeout", 64'(req_valid), 64'd1);
        t_req = $time;
        cap_addr = req_addr; cap_wdata = req_wdata; cap_wstrb = req_wstrb; cap_wen = req_wen;
        repeat (rdly) begin @(posedge clk); #1; end
        req_ready = 1;
        @(posedge clk); #1;
        req_ready = 0;
        repeat (pdly) begin @(posedge clk); #1; end
        resp_valid = 1; resp_rdata = rd;
        @(posedge clk); #1;
        resp_valid = 0; resp_rdata = {$urandom, $urandom};
        n = 0;
        while (!lsu_done && n < 20) begin @(posedge clk); #1; n++; end
        check("lsu_done timeout", 64'(lsu_done), 64'd1);
        t_done = $time;
        @(posedge clk); #1;
        inst_load = 0; inst_store = 0;
    endtask

    initial begin
        int p0;
        time t1;
        #12 rst = 0;
        @(posedge clk); #1;
        check("rst req_addr", req_addr, 64'd0);
        check("rst req_wstrb", 64'(req_wstrb), 64'd0);
        check("rst req_wdata", req_wdata, 64'd0);
        check("rst req_wen", 64'(req_wen), 64'd0);
        check("rst lsu_odata", lsu_odata, 64'd0);

        run_op(0, 1, 2'b00, 0, 64'h8000_0005, 64'hAB, 64'd0, 0, 0);
        check("sb addr", cap_addr, 64'h8000_0000);
        check("sb wstrb", 64'(cap_wstrb), 64'h20);
        check("sb wdata", cap_wdata, 64'h0000_AB00_0000_0000);
        check("sb wen", 64'(cap_wen), 64'd1);
        check("sb odata kept", lsu_odata, 64'd0);

        run_op(1, 0, 2'b00, 0, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0);
        check("lb", lsu_odata, 64'hFFFF_FFFF_FFFF_FF80);
        run_op(1, 0, 2'b00, 1, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0);
        check("lbu", lsu_odata, 64'h0000_0000_0000_0080);
        run_op(1, 0, 2'b10, 0, 64'h2004, 64'd0, 64'h8765_4321_0000_0000, 0, 0);
        check("lw", lsu_odata, 64'hFFFF_FFFF_8765_4321);
        run_op(1, 0, 2'b10, 1, 64'h2004, 64'd0, 64'h8765_4321_0000_0000, 0, 0);
        check("lwu", lsu_odata, 64'h0000_0000_8765_4321);
        run_op(1, 0, 2'b11, 0, 64'h2008, 64'd0, 64'hFEDC_BA98_7654_3210, 0, 0);
        check("ld", lsu_odata, 64'hFEDC_BA98_7654_3210);

        p0 = done_pulses;
        run_op(0, 1, 2'b01, 0, 64'h3002, 64'h1234, 64'd0, 5, 3);
        check("slow done pulses", 64'(done_pulses - p0), 64'd1);
        check("slow sh wstrb", 64'(cap_wstrb), 64'h0C);

        run_op(1, 0, 2'b01, 0, 64'h4001, 64'd0, 64'd0, 0, 0);
        check("lh odd misalign", 64'(cap_mis), 64'd1);
        check("lh odd stall", 64'(cap_stall), 64'd0);
        check("lh odd req_valid", 64'(cap_req), 64'd0);
        run_op(1, 0, 2'b11, 0, 64'h4004, 64'd0, 64'd0, 0, 0);
        check("ld off4 misalign", 64'(cap_mis), 64'd1);
        check("ld off4 req_valid", 64'(cap_req), 64'd0);

        // Reset while waiting for the response; a late response must be ignored.
        p0 = done_pulses;
        inst_load = 1; mem_size = 2'b11; load_unsigned = 0; eff_addr = 64'h5000;
        @(posedge clk); #1;
        req_ready = 1;
        @(posedge clk); #1;
        req_ready = 0; inst_load = 0;
        #2 rst = 1;
        #1 rst = 0;
        @(posedge clk); #1;
        resp_valid = 1; resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clk); #1;
        resp_valid = 0;
        check("rst-wait req_valid", 64'(req_valid), 64'd0);
        check("rst-wait lsu_done", 64'(lsu_done), 64'd0);
        @(posedge clk); #1;
        check("rst-wait no done", 64'(done_pulses - p0), 64'd0);
        check("rst-wait odata", lsu_odata, 64'd0);

        run_op(1, 0, 2'b10, 1, 64'h6000, 64'd0, 64'h0000_0000_CAFE_F00D, 0, 0);
        t1 = t_done;
        run_op(1, 0, 2'b01, 0, 64'h6006, 64'd0, 64'h8001_0000_0000_0000, 0, 0);
        check("b2b req gap", 64'(t_req - t1), 64'd20);
        check("b2b lh", lsu_odata, 64'hFFFF_FFFF_FFFF_8001);

        for (int i = 0; i < 200; i++) begin
            bit l, s, u;
            logic [1:0] sz;
            logic [63:0] a;
            int k;
            k = $urandom_range(0, 9);
            l = (k < 5); s = (k >= 5 && k < 9);
            sz = 2'($urandom_range(0, 3));
            u = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
            run_op(l, s, sz, u, a, {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
